instr_fetch_unit: RTL

//  Producer side of the 8-bit instruction interface consumed by control_unit.

---
 rtl/instr_fetch_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Holds the PC and fetches one instruction byte at a time from instruction
//   memory over a req/ack handshake. It presents each byte to decode over a
//   valid/ready handshake. Execute may redirect the PC, and a halt at accept
//   parks the unit until the next redirect. All outputs are registered.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   imem_req/imem_addr   fetch request and address, held until imem_ack
//   imem_ack/imem_rdata  memory response; ignored while imem_req=0
//   instr/instr_pc       fetched byte and the address it came from
//   instr_valid          instr/instr_pc valid; stable until instr_ready
//   instr_ready          decode accepts instr this cycle
//   redirect/redirect_pc load redirect_pc as the next fetch address
//   halt                 sampled at accept: stop fetching after this instr
module instr_fetch_unit #(
    parameter int unsigned           PC_W     = 8,
    parameter logic [PC_W-1:0]       RESET_PC = PC_W'(8'h00)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_rdata,
    output logic [7:0]      instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [PC_W-1:0] instr_pc,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt
);

    typedef enum logic [2:0] {StStart, StFetch, StHold, StDrain, StIdle} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic [7:0]      instr_q, instr_d;
    logic            valid_q, valid_d;
    logic [PC_W-1:0] instr_pc_q, instr_pc_d;
    logic [PC_W-1:0] target_q, target_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        instr_pc_d = instr_pc_q;
        target_d   = target_q;

        unique case (state_q)
            StStart: begin
                state_d = StFetch;
            end

            StFetch: begin
                if (!req_q) begin
                    // Entered FETCH with no request outstanding (after reset or a
                    // redirect): take any pending redirect, otherwise issue at pc.
                    if (redirect) begin
                        pc_d = redirect_pc;
                    end else begin
                        req_d  = 1'b1;
                        addr_d = pc_q;
                    end
                end else if (imem_ack && redirect) begin
                    pc_d  = redirect_pc;
                    req_d = 1'b0;
                end else if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + PC_W'(1);
                    valid_d    = 1'b1;
                    req_d      = 1'b0;
                    state_d    = StHold;
                end else if (redirect) begin
                    // Request is in flight: remember where to go once it lands.
                    target_d = redirect_pc;
                    state_d  = StDrain;
                end
            end

            StDrain: begin
                if (imem_ack) begin
                    pc_d    = redirect ? redirect_pc : target_q;
                    req_d   = 1'b0;
                    state_d = StFetch;
                end else if (redirect) begin
                    target_d = redirect_pc;
                end
            end

            StHold: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    state_d = StFetch;
                end else if (instr_ready) begin
                    valid_d = 1'b0;
                    if (halt) begin
                        state_d = StIdle;
                    end else begin
                        // Issue straight from accept so the next request follows
                        // on the next edge.
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = StFetch;
                    end
                end
            end

            StIdle: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = StFetch;
                end
            end

            default: begin
                state_d = StStart;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StStart;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            instr_pc_q <= '0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            instr_pc_q <= instr_pc_d;
            target_q   <= target_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign instr_pc    = instr_pc_q;

endmodule
